bcd_to_bin: RTL and testbench
=============================

// Module: bcd_to_bin
// PURPOSE
//   Sequential signed-BCD to two's-complement converter; inverse of the bcd display encoder.
//   Takes sign + three BCD digits (hundreds/tens/ones) and produces an 8-bit signed binary value.
//   Uses a reverse double-dabble loop: shift right, then subtract 3 from any BCD nibble >= 8.
//   Sits between keypad/BCD entry logic and 8-bit arithmetic datapaths.
// PARAMETERS
//   READY_HOLD  16  cycles data_ready/result stay valid in DONE before auto-return to IDLE (>=1)
// PORTS
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous, active-low reset (0 = reset)
//   start       in   1  conversion request; sampled only in IDLE or DONE
//   sign        in   1  1 = negative value
//   hundreds    in   4  BCD hundreds digit
//   tens        in   4  BCD tens digit
//   ones        in   4  BCD ones digit
//   binary      out  8  two's-complement result, held while data_ready=1
//   busy        out  1  1 while a conversion is in progress (LOAD/SHIFT/FINISH)
//   data_ready  out  1  result valid
//   err         out  1  invalid digit or out-of-range result; qualified by data_ready
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE; binary=0, busy=0, data_ready=0, err=0; all internal regs 0.
//   States: IDLE -> SHIFT -> FINISH -> DONE -> (IDLE | SHIFT).
//   IDLE: start=1 at edge k captures {hundreds,tens,ones} into 12-bit bcd_sr and sign into a sign reg.
//     The same edge clears the 12-bit mag_sr and iteration count, sets digit_bad if any digit > 9,
//     and moves to SHIFT. busy=1 from edge k.
//   SHIFT: edges k+1..k+12, one iteration per edge:
//     {bcd_sr,mag_sr} >>= 1; then for each nibble of bcd_sr: if >= 8, subtract 3.
//     After 12 iterations mag_sr = magnitude (0..999) -> FINISH.
//   FINISH (edge k+13): compute the result and enter DONE:
//     busy=0, data_ready=1, binary and err registered.
//     err = digit_bad | (!sign & mag>127) | (sign & mag>128).
//     err=1 -> binary=8'h00.
//     else binary = sign ? -mag[7:0] : mag[7:0] (8-bit two's complement).
//     -0 -> 8'h00, err=0. -128 -> 8'h80, err=0.
//   Latency: fixed 13 clocks from start-sampling edge to data_ready=1, independent of data or error.
//   DONE: data_ready=1 for up to READY_HOLD cycles, then IDLE.
//     On IDLE entry data_ready=0; binary/err keep their last value.
//   start=1 in DONE: accepted as in IDLE at that edge. data_ready drops to 0 on that edge. busy=1.
//   start while busy: ignored; no restart, no queueing; inputs not re-sampled.
//   Inputs are sampled only at the start edge; changes afterwards do not affect the result.
//   Reset mid-conversion: immediate abort to reset values; no data_ready pulse for the aborted op.
//   busy and data_ready are never both 1.
// TESTING
//   1. sign=0, 1/2/3, start 1 cycle -> data_ready rises exactly 13 clocks later; binary=8'h7B, err=0.
//   2. sign=1, 0/3/8 -> binary=8'hDA (-38), err=0. sign=1, 0/0/0 -> 8'h00, err=0.
//   3. Range edges, checked against a behavioural model over all 2x1000 legal inputs:
//      sign=1, 1/2/8 -> 8'h80, err=0.
//      sign=0, 1/2/8 -> err=1, binary=8'h00.
//      sign=0, 9/9/9 -> err=1.
//      sign=0, 1/2/7 -> 8'h7F.
//   4. tens=4'hA (others 0) -> err=1, binary=8'h00, same 13-clock latency.
//   5. start re-pulsed at cycle 5 of a conversion with new digits -> ignored; original result stays.
//      rst=0 at cycle 7 -> all outputs 0 asynchronously; no data_ready afterwards.
//   6. No start after DONE -> data_ready high exactly 16 cycles, then 0 with binary held.
//      start on the 3rd DONE cycle -> data_ready drops next edge, new result 13 clocks later.

Source files
------------

// File: rtl/bcd_to_bin.sv
// Sequential signed-BCD to 8-bit two's-complement converter.
// Reverse double-dabble: 12 shift/adjust iterations recover the binary magnitude.
module bcd_to_bin #(
    parameter int unsigned READY_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sign,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [7:0] binary,
    output logic       busy,
    output logic       data_ready,
    output logic       err
);

    localparam int unsigned HoldW = (READY_HOLD > 1) ? $clog2(READY_HOLD) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StFinish, StDone} state_e;

    state_e           state_q;
    logic [11:0]      bcd_sr_q;
    logic [11:0]      mag_sr_q;
    logic             sign_q;
    logic             digit_bad_q;
    logic [3:0]       iter_q;
    logic [HoldW-1:0] hold_q;

    logic [23:0] shifted;
    logic [11:0] bcd_adj;
    logic        accept;
    logic        res_err;
    logic [7:0]  res_bin;

    function automatic logic [3:0] adj_nibble(input logic [3:0] n);
        return (n >= 4'd8) ? n - 4'd3 : n;
    endfunction

    always_comb begin
        shifted         = {bcd_sr_q, mag_sr_q} >> 1;
        bcd_adj[3:0]    = adj_nibble(shifted[15:12]);
        bcd_adj[7:4]    = adj_nibble(shifted[19:16]);
        bcd_adj[11:8]   = adj_nibble(shifted[23:20]);
    end

    // -128 is representable, +128 is not.
    always_comb begin
        res_err = digit_bad_q | (!sign_q && (mag_sr_q > 12'd127))
                              | (sign_q && (mag_sr_q > 12'd128));
        if (res_err) begin
            res_bin = 8'h00;
        end else if (sign_q) begin
            res_bin = 8'h00 - mag_sr_q[7:0];
        end else begin
            res_bin = mag_sr_q[7:0];
        end
    end

    assign accept = start && ((state_q == StIdle) || (state_q == StDone));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            bcd_sr_q    <= '0;
            mag_sr_q    <= '0;
            sign_q      <= 1'b0;
            digit_bad_q <= 1'b0;
            iter_q      <= '0;
            hold_q      <= '0;
            binary      <= 8'h00;
            busy        <= 1'b0;
            data_ready  <= 1'b0;
            err         <= 1'b0;
        end else if (accept) begin
            bcd_sr_q    <= {hundreds, tens, ones};
            sign_q      <= sign;
            mag_sr_q    <= '0;
            iter_q      <= '0;
            digit_bad_q <= (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);
            busy        <= 1'b1;
            data_ready  <= 1'b0;
            state_q     <= StShift;
        end else begin
            case (state_q)
                StShift: begin
                    bcd_sr_q <= bcd_adj;
                    mag_sr_q <= shifted[11:0];
                    iter_q   <= iter_q + 4'd1;
                    if (iter_q == 4'd11) begin
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    binary     <= res_bin;
                    err        <= res_err;
                    busy       <= 1'b0;
                    data_ready <= 1'b1;
                    hold_q     <= '0;
                    state_q    <= StDone;
                end
                StDone: begin
                    if (hold_q == HoldW'(READY_HOLD - 1)) begin
                        data_ready <= 1'b0;
                        state_q    <= StIdle;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: cycle-level reference model plus directed vectors.
module tb_bcd_to_bin;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       sign = 1'b0;
    logic [3:0] hundreds = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic [7:0] binary;
    logic       busy;
    logic       data_ready;
    logic       err;

    int total = 0;
    int bad = 0;

    bcd_to_bin #(.READY_HOLD(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sign       (sign),
        .hundreds   (hundreds),
        .tens       (tens),
        .ones       (ones),
        .binary     (binary),
        .busy       (busy),
        .data_ready (data_ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {err, binary} from the decimal value the digits denote.
    function automatic logic [8:0] model(input logic s, input logic [3:0] h, input logic [3:0] t,
                                         input logic [3:0] o);
        int  mag;
        logic e;
        mag = h * 100 + t * 10 + o;
        e = (h > 9) || (t > 9) || (o > 9) || (!s && mag > 127) || (s && mag > 128);
        if (e) return 9'h100;
        return {1'b0, s ? 8'(256 - mag) : 8'(mag)};
    endfunction

    // Reference timing: 13 clocks latency, 16 cycles of data_ready hold.
    logic       m_busy, m_ready, m_err;
    logic [7:0] m_bin;
    logic [8:0] pend;
    int         lat, hold;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            m_bin   <= 8'h00;
            pend    <= 9'h000;
            lat     <= 0;
            hold    <= 0;
        end else if (start && !m_busy) begin
            pend    <= model(sign, hundreds, tens, ones);
            m_busy  <= 1'b1;
            m_ready <= 1'b0;
            lat     <= 13;
        end else if (m_busy) begin
            if (lat == 1) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
                m_err   <= pend[8];
                m_bin   <= pend[7:0];
                hold    <= 16;
            end
            lat <= lat - 1;
        end else if (m_ready) begin
            if (hold == 1) m_ready <= 1'b0;
            hold <= hold - 1;
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_busy));
        chk("data_ready", int'(data_ready), int'(m_ready));
        chk("binary", int'(binary), int'(m_bin));
        chk("err", int'(err), int'(m_err));
        chk("busy_and_ready", int'(busy & data_ready), 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!data_ready && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic convert(input logic s, input logic [3:0] h, input logic [3:0] t,
                           input logic [3:0] o, output int n);
        sign = s;
        hundreds = h;
        tens = t;
        ones = o;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_ready(n);
    endtask

    int n;
    int cnt;
    logic seen;

    initial begin
        // Pin the model with hand-computed values.
        chk("model_p123", int'(model(1'b0, 4'd1, 4'd2, 4'd3)), 'h07B);
        chk("model_n038", int'(model(1'b1, 4'd0, 4'd3, 4'd8)), 'h0DA);
        chk("model_n128", int'(model(1'b1, 4'd1, 4'd2, 4'd8)), 'h080);
        chk("model_p128", int'(model(1'b0, 4'd1, 4'd2, 4'd8)), 'h100);
        chk("model_p127", int'(model(1'b0, 4'd1, 4'd2, 4'd7)), 'h07F);
        chk("model_n000", int'(model(1'b1, 4'd0, 4'd0, 4'd0)), 'h000);

        tick();
        tick();
        chk("reset_bin", int'(binary), 0);
        chk("reset_flags", int'({busy, data_ready, err}), 0);
        rst = 1'b1;
        tick();

        convert(1'b0, 4'd1, 4'd2, 4'd3, n);
        chk("lat_p123", n, 13);
        chk("bin_p123", int'({err, binary}), 'h07B);

        convert(1'b1, 4'd0, 4'd3, 4'd8, n);
        chk("bin_n038", int'({err, binary}), 'h0DA);
        convert(1'b1, 4'd0, 4'd0, 4'd0, n);
        chk("bin_n000", int'({err, binary}), 'h000);

        convert(1'b0, 4'd0, 4'hA, 4'd0, n);
        chk("lat_bad_digit", n, 13);
        chk("bin_bad_digit", int'({err, binary}), 'h100);

        convert(1'b1, 4'd1, 4'd2, 4'd8, n);
        chk("bin_n128", int'({err, binary}), 'h080);
        convert(1'b0, 4'd1, 4'd2, 4'd8, n);
        chk("bin_p128", int'({err, binary}), 'h100);
        convert(1'b0, 4'd9, 4'd9, 4'd9, n);
        chk("err_p999", int'(err), 1);
        convert(1'b0, 4'd1, 4'd2, 4'd7, n);
        chk("bin_p127", int'({err, binary}), 'h07F);

        // Hold window with no new start.
        cnt = 0;
        while (data_ready && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("hold_cycles", cnt, 16);
        chk("hold_bin", int'(binary), 'h7F);

        // Restart on the third DONE cycle.
        convert(1'b0, 4'd0, 4'd4, 4'd2, n);
        tick();
        tick();
        sign = 1'b1;
        hundreds = 4'd0;
        tens = 4'd0;
        ones = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_ready_drop", int'(data_ready), 0);
        chk("restart_busy", int'(busy), 1);
        wait_ready(n);
        chk("restart_lat", n, 13);
        chk("restart_bin", int'({err, binary}), 'h0FB);

        // Start during busy is ignored.
        sign = 1'b0;
        hundreds = 4'd1;
        tens = 4'd2;
        ones = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        sign = 1'b1;
        hundreds = 4'd0;
        tens = 4'd9;
        ones = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_ready(n);
        chk("ignore_lat", n, 8);
        chk("ignore_bin", int'({err, binary}), 'h07B);

        // Asynchronous abort mid-conversion.
        sign = 1'b0;
        hundreds = 4'd0;
        tens = 4'd5;
        ones = 4'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        rst = 1'b0;
        #1;
        chk("abort_bin", int'(binary), 0);
        chk("abort_flags", int'({busy, data_ready, err}), 0);
        tick();
        tick();
        rst = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen |= data_ready;
        end
        chk("abort_no_ready", int'(seen), 0);

        // All legal magnitudes for both signs, back to back.
        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < 1000; v++) begin
                convert(1'(s), 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10), n);
                if (n != 13) chk("sweep_lat", n, 13);
            end
        end
        chk("sweep_last", int'({err, binary}), 'h100);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
